// File: rtl/stack_unit.sv
// rtl/stack_unit.sv - 16-bit LIFO stack with push/pop handshake FSM
// Each op takes IDLE -> PUSH/POP -> DONE -> IDLE; over/underflow is flagged, never wrapped.
module stack_unit #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        push_req,
  input  logic        pop_req,
  input  logic [15:0] push_data,
  output logic [15:0] pop_out,
  output logic        push_done,
  output logic        pop_done,
  output logic [15:0] sp,
  output logic        busy,
  output logic        full,
  output logic        empty,
  output logic        err
);

  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SPW = AW + 1;
  localparam logic [SPW-1:0] DEPTH_SP = SPW'(DEPTH);
  localparam logic [SPW-1:0] ONE_SP   = SPW'(1);
  localparam logic [AW-1:0]  ONE_A    = AW'(1);

  typedef enum logic [1:0] {IDLE, PUSH, POP, DONE} state_t;

  state_t          state;
  logic [SPW-1:0]  sp_q;
  logic [15:0]     data_q;
  logic [15:0]     mem [DEPTH];
  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   rd_idx;
  logic            can_push;
  logic            can_pop;

  assign can_push = (sp_q != DEPTH_SP);
  assign can_pop  = (sp_q != '0);
  assign wr_idx   = sp_q[AW-1:0];
  // When sp == DEPTH the low bits are zero, so the decrement lands on DEPTH-1.
  assign rd_idx   = sp_q[AW-1:0] - ONE_A;

  assign sp    = 16'(sp_q);
  assign busy  = (state != IDLE);
  assign full  = (sp_q == DEPTH_SP);
  assign empty = (sp_q == '0);

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state     <= IDLE;
      sp_q      <= '0;
      pop_out   <= 16'h0000;
      push_done <= 1'b0;
      pop_done  <= 1'b0;
      err       <= 1'b0;
      data_q    <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (push_req) begin
            data_q <= push_data;
            state  <= PUSH;
          end else if (pop_req) begin
            state  <= POP;
          end
        end
        PUSH: begin
          if (can_push) begin
            sp_q <= sp_q + ONE_SP;
            err  <= 1'b0;
          end else begin
            err  <= 1'b1;
          end
          push_done <= 1'b1;
          state     <= DONE;
        end
        POP: begin
          if (can_pop) begin
            pop_out <= mem[rd_idx];
            sp_q    <= sp_q - ONE_SP;
            err     <= 1'b0;
          end else begin
            err     <= 1'b1;
          end
          pop_done <= 1'b1;
          state    <= DONE;
        end
        default: begin
          push_done <= 1'b0;
          pop_done  <= 1'b0;
          err       <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Storage is never reset; sp bounds every read to written entries.
  always_ff @(posedge clk) begin
    if (!rst_b && state == PUSH && can_push) begin
      mem[wr_idx] <= data_q;
    end
  end

endmodule

// File: tb/tb_stack_unit.sv
// tb/tb_stack_unit.sv - scoreboard bench for stack_unit
// Driver queues expected completions; a negedge monitor checks every done pulse.
module tb_stack_unit;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        push_req;
  logic        pop_req;
  logic [15:0] push_data;
  logic [15:0] pop_out;
  logic        push_done;
  logic        pop_done;
  logic [15:0] sp;
  logic        busy;
  logic        full;
  logic        empty;
  logic        err;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        is_push;
    logic        err;
    logic [15:0] pop_out;
    logic [15:0] sp;
  } exp_t;

  exp_t exp_q[$];

  stack_unit #(.DEPTH(64)) dut (
    .clk(clk), .rst_b(rst_b), .push_req(push_req), .pop_req(pop_req),
    .push_data(push_data), .pop_out(pop_out), .push_done(push_done),
    .pop_done(pop_done), .sp(sp), .busy(busy), .full(full), .empty(empty),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (push_done || pop_done) begin
      chk("done_exclusive", {31'd0, push_done & pop_done}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done_kind", {31'd0, push_done}, {31'd0, e.is_push});
        chk("err", {31'd0, err}, {31'd0, e.err});
        chk("sp", {16'd0, sp}, {16'd0, e.sp});
        if (!e.is_push) chk("pop_out", {16'd0, pop_out}, {16'd0, e.pop_out});
      end
    end
  end

  // Issues one op at a negedge and checks the 3-cycle timeline; optionally
  // re-asserts requests while the DUT sits in DONE.
  task automatic op(input logic do_push, input logic do_pop, input logic [15:0] data,
                    input logic e_err, input logic [15:0] e_pop, input logic [15:0] e_sp,
                    input logic hold_in_done);
    exp_t e;
    e.is_push = do_push;
    e.err     = e_err;
    e.pop_out = e_pop;
    e.sp      = e_sp;
    @(negedge clk);
    push_req  = do_push;
    pop_req   = do_pop;
    push_data = data;
    exp_q.push_back(e);
    @(negedge clk);
    push_req = 1'b0;
    pop_req  = 1'b0;
    chk("busy_after_req", {31'd0, busy}, 32'd1);
    chk("no_early_done", {30'd0, push_done, pop_done}, 32'd0);
    @(negedge clk);
    chk("done_on_time", {31'd0, push_done | pop_done}, 32'd1);
    if (hold_in_done) begin
      push_req = 1'b1;
      pop_req  = 1'b1;
    end
    @(negedge clk);
    push_req = 1'b0;
    pop_req  = 1'b0;
    chk("done_one_cycle", {30'd0, push_done, pop_done}, 32'd0);
    chk("idle_after_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst_b = 1'b1; push_req = 1'b0; pop_req = 1'b0; push_data = 16'h0;
    repeat (3) @(negedge clk);
    rst_b = 1'b0;
    chk("rst_sp", {16'd0, sp}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pop_out", {16'd0, pop_out}, 32'd0);
    chk("rst_flags", {29'd0, push_done, pop_done, err}, 32'd0);

    op(1, 0, 16'h1234, 0, 16'h0000, 16'd1, 0);
    op(1, 0, 16'hBEEF, 0, 16'h0000, 16'd2, 0);
    chk("full_at_2", {31'd0, full}, 32'd0);

    op(0, 1, 16'h0000, 0, 16'hBEEF, 16'd1, 0);
    op(0, 1, 16'h0000, 0, 16'h1234, 16'd0, 0);
    chk("empty_after_pops", {31'd0, empty}, 32'd1);

    op(0, 1, 16'h0000, 1, 16'h1234, 16'd0, 0);

    for (int i = 0; i < 64; i++) op(1, 0, 16'(i), 0, 16'h0000, 16'(i + 1), 0);
    chk("full_at_64", {31'd0, full}, 32'd1);
    op(1, 0, 16'hFFFF, 1, 16'h0000, 16'd64, 0);
    op(0, 1, 16'h0000, 0, 16'h003F, 16'd63, 0);

    op(1, 1, 16'h00AA, 0, 16'h0000, 16'd64, 1);
    repeat (4) @(negedge clk);
    chk("no_op_from_done_reqs", {16'd0, sp}, 32'd64);
    op(0, 1, 16'h0000, 0, 16'h00AA, 16'd63, 0);

    // Reset while the DUT sits in PUSH: no done pulse, sp cleared.
    @(negedge clk);
    push_req = 1'b1; push_data = 16'h5555;
    @(negedge clk);
    push_req = 1'b0;
    chk("in_push_busy", {31'd0, busy}, 32'd1);
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    chk("abort_no_done", {30'd0, push_done, pop_done}, 32'd0);
    chk("abort_sp", {16'd0, sp}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);

    op(0, 1, 16'h0000, 1, 16'h0000, 16'd0, 0);
    op(1, 0, 16'h0F0F, 0, 16'h0000, 16'd1, 0);
    op(0, 1, 16'h0000, 0, 16'h0F0F, 16'd0, 0);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
